// File: rtl/jt12_mod_seq.sv
// Operator slot sequencer for a YM2612-style FM core: walks channel/operator
// slots and registers which earlier outputs feed the current operator's modulator.
module jt12_mod_seq #(
  parameter int NUM_CH = 6
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       clk_en,
  input  logic       zero,
  input  logic       alg_we,
  input  logic [2:0] alg_ch,
  input  logic [2:0] alg_din,
  output logic       s1_enters,
  output logic       s2_enters,
  output logic       s3_enters,
  output logic       s4_enters,
  output logic [2:0] cur_ch,
  output logic       xuse_prevprev1,
  output logic       xuse_prev2,
  output logic       xuse_internal,
  output logic       yuse_prev1,
  output logic       yuse_prev2,
  output logic       yuse_internal,
  output logic       use_err,
  output logic       sync_err
);

  localparam logic [4:0] LAST = 5'(4 * NUM_CH - 1);

  logic [4:0] cnt;
  logic [2:0] alg_mem [8];
  logic [2:0] ch;
  logic [2:0] alg;
  logic [1:0] grp;
  logic [7:0] a_hot;
  logic       s1, s2, s3, s4;
  logic       xpp1, xp2, xint, yp1, yp2, yint;
  logic       x_over, y_over;

  // Slot groups run S1, S3, S2, S4 as the counter advances.
  always_comb begin
    ch  = 3'(cnt % 5'(NUM_CH));
    grp = 2'(cnt / 5'(NUM_CH));
    alg = alg_mem[ch];
    s1  = (grp == 2'd0);
    s3  = (grp == 2'd1);
    s2  = (grp == 2'd2);
    s4  = (grp == 2'd3);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hot
      assign a_hot[gi] = (alg == 3'(gi));
    end

    if (NUM_CH == 6) begin : g_dec6
      always_comb begin
        xpp1 = s1 | (s3 & a_hot[5]);
        xp2  = (s3 & |a_hot[2:0]) | (s4 & a_hot[3]);
        xint = s4 & a_hot[2];
        yint = s4 & |(a_hot & 8'b0001_1011);
        yp1  = s1 | (s3 & a_hot[1]) | (s2 & |(a_hot & 8'b0111_1001))
               | (s4 & |(a_hot & 8'b0010_0100));
        yp2  = 1'b0;
      end
    end else begin : g_dec3
      always_comb begin
        xpp1 = s4 & |(a_hot & 8'b0001_1111);
        xp2  = s3 & a_hot[1];
        xint = s1;
        yint = 1'b0;
        yp1  = s1 | (s2 & |(a_hot & 8'b0111_1001))
               | (s3 & |(a_hot & 8'b0010_0010))
               | (s4 & |(a_hot & 8'b0010_0100));
        yp2  = (s3 & |(a_hot & 8'b0000_0101)) | (s4 & a_hot[3]);
      end
    end
  endgenerate

  always_comb begin
    x_over = $countones({xpp1, xp2, xint}) > 1;
    y_over = $countones({yp1, yp2, yint}) > 1;
  end

  // Algorithm writes ignore clk_en; a write to the slot being decoded lands after the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) alg_mem[i] <= 3'd0;
    end else if (alg_we && (alg_ch < 3'(NUM_CH))) begin
      alg_mem[alg_ch] <= alg_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= 5'd0;
      s1_enters      <= 1'b0;
      s2_enters      <= 1'b0;
      s3_enters      <= 1'b0;
      s4_enters      <= 1'b0;
      cur_ch         <= 3'd0;
      xuse_prevprev1 <= 1'b0;
      xuse_prev2     <= 1'b0;
      xuse_internal  <= 1'b0;
      yuse_prev1     <= 1'b0;
      yuse_prev2     <= 1'b0;
      yuse_internal  <= 1'b0;
      use_err        <= 1'b0;
      sync_err       <= 1'b0;
    end else if (clk_en) begin
      s1_enters      <= s1;
      s2_enters      <= s2;
      s3_enters      <= s3;
      s4_enters      <= s4;
      cur_ch         <= ch;
      xuse_prevprev1 <= xpp1;
      xuse_prev2     <= xp2;
      xuse_internal  <= xint;
      yuse_prev1     <= yp1;
      yuse_prev2     <= yp2;
      yuse_internal  <= yint;
      if (x_over || y_over) use_err <= 1'b1;
      // A frame marker anywhere but the last slot means we had drifted.
      if (zero) begin
        cnt <= 5'd0;
        if (cnt != LAST) sync_err <= 1'b1;
      end else begin
        cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_jt12_mod_seq.sv
// Scoreboard bench: drives 6- and 3-channel instances with shared stimulus and
// checks both against an operator-level reference model.
module tb_jt12_mod_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0, zero = 1'b0, alg_we = 1'b0;
  logic [2:0] alg_ch = 3'd0, alg_din = 3'd0;

  logic       a_s1, a_s2, a_s3, a_s4, a_xpp1, a_xp2, a_xint, a_yp1, a_yp2, a_yint, a_ue, a_se;
  logic [2:0] a_ch;
  logic       b_s1, b_s2, b_s3, b_s4, b_xpp1, b_xp2, b_xint, b_yp1, b_yp2, b_yint, b_ue, b_se;
  logic [2:0] b_ch;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jt12_mod_seq #(.NUM_CH(6)) dut6 (
    .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero), .alg_we(alg_we),
    .alg_ch(alg_ch), .alg_din(alg_din),
    .s1_enters(a_s1), .s2_enters(a_s2), .s3_enters(a_s3), .s4_enters(a_s4),
    .cur_ch(a_ch), .xuse_prevprev1(a_xpp1), .xuse_prev2(a_xp2), .xuse_internal(a_xint),
    .yuse_prev1(a_yp1), .yuse_prev2(a_yp2), .yuse_internal(a_yint),
    .use_err(a_ue), .sync_err(a_se)
  );

  jt12_mod_seq #(.NUM_CH(3)) dut3 (
    .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero), .alg_we(alg_we),
    .alg_ch(alg_ch), .alg_din(alg_din),
    .s1_enters(b_s1), .s2_enters(b_s2), .s3_enters(b_s3), .s4_enters(b_s4),
    .cur_ch(b_ch), .xuse_prevprev1(b_xpp1), .xuse_prev2(b_xp2), .xuse_internal(b_xint),
    .yuse_prev1(b_yp1), .yuse_prev2(b_yp2), .yuse_internal(b_yint),
    .use_err(b_ue), .sync_err(b_se)
  );

  logic [14:0] act6, act3;
  assign act6 = {a_s1, a_s2, a_s3, a_s4, a_ch, a_xpp1, a_xp2, a_xint, a_yp1, a_yp2, a_yint, a_ue, a_se};
  assign act3 = {b_s1, b_s2, b_s3, b_s4, b_ch, b_xpp1, b_xp2, b_xint, b_yp1, b_yp2, b_yint, b_ue, b_se};

  // Reference model state, index 0 = 6 channels, index 1 = 3 channels.
  int          nch [2] = '{6, 3};
  int          m_cnt [2];
  logic [2:0]  m_alg [2][8];
  bit          m_uerr [2];
  bit          m_serr [2];
  logic [14:0] m_out [2];
  logic [14:0] q6 [$];
  logic [14:0] q3 [$];

  // Returns {s1,s2,s3,s4, ch[2:0], xpp1,xp2,xint, yp1,yp2,yint} for slot c.
  function automatic logic [12:0] ref_decode(int n, int c, int a);
    int op;
    bit xpp1, xp2, xint, yp1, yp2, yint;
    case (c / n)
      0: op = 1;
      1: op = 3;
      2: op = 2;
      default: op = 4;
    endcase
    {xpp1, xp2, xint, yp1, yp2, yint} = 6'b0;
    if (n == 6) begin
      case (op)
        1: begin xpp1 = 1; yp1 = 1; end
        2: yp1 = a inside {0, 3, 4, 5, 6};
        3: begin xpp1 = (a == 5); xp2 = (a <= 2); yp1 = (a == 1); end
        default: begin
          xp2 = (a == 3); xint = (a == 2);
          yint = a inside {0, 1, 3, 4}; yp1 = a inside {2, 5};
        end
      endcase
    end else begin
      case (op)
        1: begin xint = 1; yp1 = 1; end
        2: yp1 = a inside {0, 3, 4, 5, 6};
        3: begin yp1 = a inside {1, 5}; yp2 = a inside {0, 2}; xp2 = (a == 1); end
        default: begin
          yp1 = a inside {2, 5}; xpp1 = a inside {0, 1, 2, 3, 4}; yp2 = (a == 3);
        end
      endcase
    end
    return {op == 1, op == 2, op == 3, op == 4, 3'(c % n), xpp1, xp2, xint, yp1, yp2, yint};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_uerr[k] = 0; m_serr[k] = 0; m_out[k] = '0;
      for (int j = 0; j < 8; j++) m_alg[k][j] = 3'd0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n;
      logic [12:0] d;
      n = nch[k];
      if (clk_en) begin
        d = ref_decode(n, m_cnt[k], int'(m_alg[k][m_cnt[k] % n]));
        if (int'(d[5]) + int'(d[4]) + int'(d[3]) > 1 || int'(d[2]) + int'(d[1]) + int'(d[0]) > 1)
          m_uerr[k] = 1;
        if (zero) begin
          if (m_cnt[k] != 4 * n - 1) m_serr[k] = 1;
          m_cnt[k] = 0;
        end else begin
          m_cnt[k] = (m_cnt[k] + 1) % (4 * n);
        end
        m_out[k] = {d, m_uerr[k], m_serr[k]};
      end
      if (alg_we && int'(alg_ch) < n) m_alg[k][alg_ch] = alg_din;
    end
    q6.push_back(m_out[0]);
    q3.push_back(m_out[1]);
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUTs.
  task automatic step(input bit ce, input bit z, input bit we, input logic [2:0] ch, input logic [2:0] din);
    clk_en = ce; zero = z; alg_we = we; alg_ch = ch; alg_din = din;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (act6 !== 15'd0) begin
      errors++;
      $display("FAIL %s n=6: got %b want %b", tag, act6, 15'd0);
    end
    checks++;
    if (act3 !== 15'd0) begin
      errors++;
      $display("FAIL %s n=3: got %b want %b", tag, act3, 15'd0);
    end
  endtask

  // Monitor: every clock edge presents a (possibly held) output word.
  always @(negedge clk) begin
    logic [14:0] e;
    while (q6.size() > 0) begin
      e = q6.pop_front();
      checks++;
      if (act6 !== e) begin
        errors++;
        $display("FAIL out n=6: got %b want %b", act6, e);
      end else begin
        $display("txn n=6 out=%b ok", act6);
      end
    end
    while (q3.size() > 0) begin
      e = q3.pop_front();
      checks++;
      if (act3 !== e) begin
        errors++;
        $display("FAIL out n=3: got %b want %b", act3, e);
      end else begin
        $display("txn n=3 out=%b ok", act3);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Full frame from reset, then a frame marker exactly on the last 6-channel slot.
    repeat (23) step(1, 0, 0, 3'd0, 3'd0);
    step(1, 1, 0, 3'd0, 3'd0);

    // Channel 2 = alg 5, channel 1 = alg 3, written while the sequencer is idle.
    step(0, 0, 1, 3'd2, 3'd5);
    step(0, 1, 1, 3'd1, 3'd3);
    repeat (24) step(1, 0, 0, 3'd0, 3'd0);

    // Every algorithm on every channel for a full frame.
    for (int a = 0; a < 8; a++) begin
      for (int c = 0; c < 6; c++) step(0, 0, 1, 3'(c), 3'(a));
      repeat (24) step(1, 0, 0, 3'd0, 3'd0);
    end

    // Resync, overwrite ch0 during its own S1 slot, then a misaligned marker at slot 5.
    step(1, 1, 0, 3'd0, 3'd0);
    step(1, 0, 1, 3'd0, 3'd2);
    repeat (4) step(1, 0, 0, 3'd0, 3'd0);
    step(1, 1, 0, 3'd0, 3'd0);
    repeat (24) step(1, 0, 0, 3'd0, 3'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Asynchronous reset mid-frame with no clock edge in between.
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    model_reset();
    #1 rst = 1'b0;
    step(1, 0, 0, 3'd0, 3'd0);
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    for (int i = 0; i < 5 && (q6.size() > 0 || q3.size() > 0); i++) @(negedge clk);
    if (q6.size() > 0 || q3.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", q6.size() + q3.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt12_mod_seq.md
JT12_MOD_SEQ -- requirements
Module: jt12_mod_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, meaning channel count; the only legal values are 3 and 6.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clk_en, input, 1 bit: slot advance enable; state holds when low, except alg writes.
REQ-005 SHALL have port zero, input, 1 bit: frame-start marker.
REQ-006 SHALL have port alg_we, input, 1 bit: algorithm write strobe.
REQ-007 SHALL have port alg_ch, input, 3 bits: channel written; values >= NUM_CH are ignored.
REQ-008 SHALL have port alg_din, input, 3 bits: algorithm value 0..7.
REQ-009 SHALL have outputs s1_enters, s2_enters, s3_enters, s4_enters, 1 bit each: registered one-hot current operator.
REQ-010 SHALL have output cur_ch, 3 bits: registered channel of the current slot.
REQ-011 SHALL have outputs xuse_prevprev1, xuse_prev2, xuse_internal, yuse_prev1, yuse_prev2, yuse_internal, 1 bit each: registered modulator-source selects.
REQ-012 SHALL have output use_err, 1 bit: sticky flag for x or y overuse.
REQ-013 SHALL have output sync_err, 1 bit: sticky flag for a misaligned zero.

Function
REQ-014 SHALL keep slot counter cnt, 0..4*NUM_CH-1, incremented on each clk_en and wrapping to 0 after 4*NUM_CH-1.
REQ-015 SHALL derive channel = cnt mod NUM_CH; operator group = cnt div NUM_CH, in order S1, S3, S2, S4.
REQ-016 SHALL hold an NUM_CH-entry 3-bit alg array; a write with alg_we=1 takes place on any clk edge, regardless of clk_en.
REQ-017 SHALL, when a write hits the channel being decoded in the same cycle, decode with the old alg value; the new value applies from the next read.
REQ-018 SHALL, on each clk_en, register the s*_enters, cur_ch and use outputs decoded from the current cnt and alg; latency is 1 clk_en from counter value to outputs.
REQ-019 SHALL decode for NUM_CH=6:
- xuse_prevprev1 = S1 | S3&alg5
- xuse_prev2 = S3&alg{0,1,2} | S4&alg3
- xuse_internal = S4&alg2
- yuse_internal = S4&alg{0,1,3,4}
- yuse_prev1 = S1 | S3&alg1 | S2&alg{0,3,4,5,6} | S4&alg{2,5}
- yuse_prev2 = 0
REQ-020 SHALL decode for NUM_CH=3, with all unlisted flags 0:
- S1: xuse_internal, yuse_prev1
- S2: yuse_prev1 if alg{0,3,4,5,6}
- S3: yuse_prev1 if alg5; yuse_prev2 if alg{0,2}; xuse_prev2 and yuse_prev1 if alg1
- S4: yuse_prev1 if alg5; xuse_prevprev1 if alg{0,1,4}; xuse_prevprev1 and yuse_prev2 if alg3; xuse_prevprev1 and yuse_prev1 if alg2
REQ-021 SHALL, when zero=1 coincides with clk_en, load cnt=0 on that edge (resynchronise).
REQ-022 SHALL set sync_err on that edge if cnt was not 4*NUM_CH-1 at the time.
REQ-023 SHALL set use_err if, on any registered output, xuse_prevprev1+xuse_prev2+xuse_internal > 1 or yuse_prev1+yuse_prev2+yuse_internal > 1.
REQ-024 SHALL keep use_err and sync_err set until rst.
REQ-025 SHALL ignore zero and leave the outputs unchanged when clk_en=0.

Reset
REQ-026 SHALL, while rst=1, asynchronously force cnt=0, all alg entries=0, every output=0 and both error flags=0.
REQ-027 SHALL abandon any frame in progress when rst is asserted mid-frame; the first clk_en after release registers slot cnt=0 (S1, channel 0).

Verification
REQ-028 SHALL cover: NUM_CH=6, all algs 0, run 24 clk_en -> s1_enters high for 6 slots with cur_ch 0..5, then S3, S2, S4; S4 shows xuse_prev2=0, yuse_internal=1.
REQ-029 SHALL cover: NUM_CH=6, ch2 alg=5, S3 slot of ch2 -> xuse_prevprev1=1, yuse_prev1=0.
REQ-030 SHALL cover: NUM_CH=3, ch1 alg=3, S4 slot of ch1 -> xuse_prevprev1=1, yuse_prev2=1, use_err stays 0 over all 8 algs.
REQ-031 SHALL cover: zero at cnt=5 -> cnt=0 next, sync_err=1 and held; zero at cnt=23 -> sync_err stays 0.
REQ-032 SHALL cover: alg write to ch0 during the S1 slot of ch0 -> that slot uses the old alg; the S3 slot of ch0 uses the new alg.
REQ-033 SHALL cover: rst pulsed mid-frame without a clock edge -> outputs read 0 immediately; next clk_en gives s1_enters=1, cur_ch=0.
